// File: rtl/led_regfile.sv
// led_regfile: double-buffered LED colour bank fed by an I2C slave.
// Bytes land in a shadow buffer through an auto-incrementing pointer.
// An I2C STOP copies the shadow into the active buffer, which the LED
// driver reads through a registered index port.
//
// Handshake: there is no valid/ready pair. A byte is accepted on the
// rising edge of data_valid and the pointer is loaded on the rising edge
// of address_valid. The block never stalls, so the upstream slave needs
// no backpressure.
module led_regfile #(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       address,
  input  logic [7:0]       data,
  input  logic             address_valid,
  input  logic             data_valid,
  input  logic             start,
  input  logic             stop,
  input  logic [IDX_W-1:0] led_idx,
  output logic [23:0]      led_rgb,
  output logic             update,
  output logic             blank
);

  localparam int DEPTH = 3 * NUM_LEDS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ADDR = 2'd1;
  localparam logic [1:0] S_WRITE     = 2'd2;
  localparam logic [1:0] S_COMMIT    = 2'd3;

  logic [1:0]  r_state;
  logic        r_dv_q;
  logic        r_av_q;
  logic [7:0]  r_ptr;
  logic        r_dirty;
  logic [7:0]  r_ctrl;
  logic        r_update;
  logic [23:0] r_led_rgb;
  logic [7:0]  r_shadow [DEPTH];
  logic [7:0]  r_active [DEPTH];

  logic        w_dv_rise;
  logic        w_av_rise;
  logic        w_wr;
  logic        w_wr_buf;
  logic        w_dirty_next;
  logic [23:0] w_rgb;

  assign w_dv_rise    = data_valid & ~r_dv_q;
  assign w_av_rise    = address_valid & ~r_av_q;
  // A byte only counts while a transaction is in its data phase.
  assign w_wr         = w_dv_rise && (r_state == S_WRITE);
  assign w_wr_buf     = w_wr && (r_ptr < 8'(DEPTH));
  // A STOP arriving with the last byte must still see that byte as dirty.
  assign w_dirty_next = r_dirty | w_wr_buf;

  // Edge-detect history for the level strobes from the slave.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dv_q <= 1'b0;
      r_av_q <= 1'b0;
    end else begin
      r_dv_q <= data_valid;
      r_av_q <= address_valid;
    end
  end

  // Transaction FSM; START always wins except that COMMIT finishes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_WAIT_ADDR;
        end
        S_WAIT_ADDR: begin
          if (start)          r_state <= S_WAIT_ADDR;
          else if (w_av_rise) r_state <= S_WRITE;
          else if (stop)      r_state <= r_dirty ? S_COMMIT : S_IDLE;
        end
        S_WRITE: begin
          if (start)     r_state <= S_WAIT_ADDR;
          else if (stop) r_state <= w_dirty_next ? S_COMMIT : S_IDLE;
        end
        default: begin
          r_state <= start ? S_WAIT_ADDR : S_IDLE;
        end
      endcase
    end
  end

  // Pointer: loaded from the register address, advanced per accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 8'd0;
    end else if (r_state == S_WAIT_ADDR && !start && w_av_rise) begin
      r_ptr <= address;
    end else if (w_wr) begin
      if (r_ptr < 8'(DEPTH - 1))       r_ptr <= r_ptr + 8'd1;
      else if (r_ptr == 8'(DEPTH - 1)) r_ptr <= 8'd0;
    end
  end

  // Control register at address 0xFF; takes effect without a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= 8'd0;
    end else if (w_wr && r_ptr == 8'hFF) begin
      r_ctrl <= data;
    end
  end

  // Shadow buffer writes and the dirty flag that gates a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < DEPTH; b++) r_shadow[b] <= 8'd0;
      r_dirty <= 1'b0;
    end else begin
      if (w_wr_buf) begin
        for (int b = 0; b < DEPTH; b++) begin
          if (r_ptr == 8'(b)) r_shadow[b] <= data;
        end
      end
      if (r_state == S_COMMIT) r_dirty <= 1'b0;
      else if (w_wr_buf)       r_dirty <= 1'b1;
    end
  end

  // Whole-buffer copy in the single COMMIT cycle, with the update pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < DEPTH; b++) r_active[b] <= 8'd0;
      r_update <= 1'b0;
    end else begin
      r_update <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        for (int b = 0; b < DEPTH; b++) r_active[b] <= r_shadow[b];
      end
    end
  end

  // Select the three active bytes of the requested LED; unknown index reads 0.
  always_comb begin
    w_rgb = 24'd0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (int'(led_idx) == i) w_rgb = {r_active[3*i], r_active[3*i+1], r_active[3*i+2]};
    end
  end

  // Registered read port, forced dark while blank is set.
  always_ff @(posedge clk) begin
    if (reset) r_led_rgb <= 24'd0;
    else       r_led_rgb <= r_ctrl[0] ? 24'd0 : w_rgb;
  end

  assign led_rgb = r_led_rgb;
  assign update  = r_update;
  assign blank   = r_ctrl[0];

endmodule

// File: tb/tb_led_regfile.sv
// Directed bench for led_regfile: linear stimulus, hand-computed expectations.
module tb_led_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  address = 8'd0;
  logic [7:0]  data = 8'd0;
  logic        address_valid = 1'b0;
  logic        data_valid = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  led_idx = 3'd0;
  logic [23:0] led_rgb;
  logic        update;
  logic        blank;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int upd_base;

  led_regfile #(.NUM_LEDS(8), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .address_valid(address_valid), .data_valid(data_valid),
    .start(start), .stop(stop), .led_idx(led_idx),
    .led_rgb(led_rgb), .update(update), .blank(blank)
  );

  // Clock
  always #5 clk = ~clk;

  // Count update pulses seen at each rising edge.
  always @(posedge clk) if (update === 1'b1) upd_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_addr(input logic [7:0] a);
    address_valid = 1'b0;
    cyc(1);
    address = a;
    address_valid = 1'b1;
    cyc(1);
  endtask

  task automatic do_byte(input logic [7:0] d, input int hold);
    data = d;
    data_valid = 1'b1;
    cyc(hold);
    data_valid = 1'b0;
    cyc(1);
  endtask

  task automatic do_stop();
    address_valid = 1'b0;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic read_led(input int idx, input logic [23:0] exp, input string tag);
    led_idx = 3'(idx);
    cyc(1);
    chk(32'(led_rgb), 32'(exp), tag);
  endtask

  initial begin
    // 1. Reset state
    cyc(3);
    reset = 1'b0;
    chk(32'(update), 32'd0, "reset_update");
    chk(32'(blank), 32'd0, "reset_blank");
    chk(32'(led_rgb), 32'd0, "reset_rgb");
    for (int i = 0; i < 8; i++) read_led(i, 24'h0, "reset_led");

    // 2. Basic write and commit on STOP
    upd_base = upd_cnt;
    do_start();
    do_addr(8'h00);
    do_byte(8'h11, 1);
    do_byte(8'h22, 1);
    do_byte(8'h33, 1);
    read_led(0, 24'h0, "t2_before_stop");
    do_stop();
    chk(32'(update), 32'd0, "t2_update_early");
    cyc(1);
    chk(32'(update), 32'd1, "t2_update_pulse");
    cyc(1);
    chk(32'(update), 32'd0, "t2_update_end");
    read_led(0, 24'h112233, "t2_led0");
    chk(32'(upd_cnt - upd_base), 32'd1, "t2_update_count");

    // 3. Pointer wrap from the last byte back to byte 0
    do_reset();
    do_start();
    do_addr(8'h17);
    do_byte(8'hAA, 1);
    do_byte(8'hBB, 1);
    do_stop();
    cyc(2);
    read_led(7, 24'h0000AA, "t3_led7");
    read_led(0, 24'hBB0000, "t3_led0");

    // 4. Control register blank, no commit
    upd_base = upd_cnt;
    do_start();
    do_addr(8'hFF);
    do_byte(8'h01, 1);
    chk(32'(blank), 32'd1, "t4_blank_immediate");
    do_stop();
    cyc(3);
    chk(32'(upd_cnt - upd_base), 32'd0, "t4_no_update");
    read_led(0, 24'h0, "t4_blank_led0");
    read_led(7, 24'h0, "t4_blank_led7");
    do_start();
    do_addr(8'hFF);
    do_byte(8'h00, 1);
    do_stop();
    cyc(3);
    chk(32'(blank), 32'd0, "t4_unblank");
    read_led(0, 24'hBB0000, "t4_led0_back");
    read_led(7, 24'h0000AA, "t4_led7_back");
    chk(32'(upd_cnt - upd_base), 32'd0, "t4_still_no_update");

    // 5. Repeated start, long data_valid levels, single commit
    upd_base = upd_cnt;
    do_start();
    do_addr(8'h00);
    do_byte(8'h01, 20);
    do_byte(8'h02, 20);
    do_byte(8'h03, 20);
    address_valid = 1'b0;
    do_start();
    do_addr(8'h03);
    do_byte(8'h04, 20);
    do_byte(8'h05, 20);
    do_byte(8'h06, 20);
    do_stop();
    cyc(3);
    chk(32'(upd_cnt - upd_base), 32'd1, "t5_one_update");
    read_led(0, 24'h010203, "t5_led0");
    read_led(1, 24'h040506, "t5_led1");
    read_led(2, 24'h000000, "t5_led2");

    // 6a. STOP coincident with the last byte
    upd_base = upd_cnt;
    do_start();
    do_addr(8'h09);
    do_byte(8'h7A, 1);
    do_byte(8'h7B, 1);
    data = 8'h7C;
    data_valid = 1'b1;
    address_valid = 1'b0;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    data_valid = 1'b0;
    cyc(1);
    read_led(3, 24'h7A7B7C, "t6_led3");
    chk(32'(upd_cnt - upd_base), 32'd1, "t6_update");

    // 6b. Reset in the middle of a write transaction
    upd_base = upd_cnt;
    do_start();
    do_addr(8'h00);
    do_byte(8'h55, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    do_stop();
    cyc(3);
    chk(32'(update), 32'd0, "t6_reset_update");
    chk(32'(upd_cnt - upd_base), 32'd0, "t6_reset_no_pulse");
    chk(32'(blank), 32'd0, "t6_reset_blank");
    read_led(0, 24'h0, "t6_reset_led0");
    read_led(3, 24'h0, "t6_reset_led3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
